// File: rtl/pipe_pkg.sv
// Shared types and helpers for the flow-controlled pipeline boundary register.
package pipe_pkg;

    localparam bit SKID_OFF  = 1'b0;
    localparam bit SKID_ON   = 1'b1;
    localparam int SAT_MAX_W = 32;

    typedef struct packed {
        logic       rf_we;
        logic       im_to_rf;
        logic       store;
        logic       load;
        logic [1:0] next_pc_sel;
        logic [1:0] spare;
    } pipe_ctrl_t;

    // Increment, holding at the all-ones value of a cnt_w-bit counter.
    function automatic logic [SAT_MAX_W-1:0] sat_inc(input logic [SAT_MAX_W-1:0] cnt,
                                                     input int cnt_w);
        logic [SAT_MAX_W-1:0] max_v;
        max_v = (cnt_w >= SAT_MAX_W) ? '1 : ((SAT_MAX_W'(1) << cnt_w) - SAT_MAX_W'(1));
        return (cnt == max_v) ? cnt : cnt + SAT_MAX_W'(1);
    endfunction

endpackage

// File: rtl/pipe_slot.sv
// One pipeline entry: valid flag plus payload and control registers.
module pipe_slot #(
    parameter int DATA_W = 32,
    parameter int CTRL_W = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              load_i,
    input  logic              clear_i,
    input  logic [DATA_W-1:0] data_i,
    input  logic [CTRL_W-1:0] ctrl_i,
    output logic              valid_o,
    output logic [DATA_W-1:0] data_o,
    output logic [CTRL_W-1:0] ctrl_o
);

    logic              valid_q, valid_d;
    logic [DATA_W-1:0] data_q, data_d;
    logic [CTRL_W-1:0] ctrl_q, ctrl_d;

    // Load wins over clear so a drain and refill in one cycle leaves the slot full.
    always_comb begin
        valid_d = valid_q;
        data_d  = data_q;
        ctrl_d  = ctrl_q;
        if (load_i) begin
            valid_d = 1'b1;
            data_d  = data_i;
            ctrl_d  = ctrl_i;
        end else if (clear_i) begin
            valid_d = 1'b0;
        end
    end

    // NOTE: payload registers are reset too so out_data is defined from reset onwards.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid_q <= 1'b0;
            data_q  <= '0;
            ctrl_q  <= '0;
        end else begin
            valid_q <= valid_d;
            data_q  <= data_d;
            ctrl_q  <= ctrl_d;
        end
    end

    assign valid_o = valid_q;
    assign data_o  = data_q;
    assign ctrl_o  = ctrl_q;

endmodule

// File: rtl/pipe_stage_reg.sv
// Valid/ready pipeline boundary register with flush, optional skid slot and stall counter.
module pipe_stage_reg
    import pipe_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int CTRL_W = $bits(pipe_ctrl_t),
    parameter bit SKID   = SKID_ON,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    input  logic [CTRL_W-1:0] in_ctrl,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic [CTRL_W-1:0] out_ctrl,
    output logic [CNT_W-1:0]  stall_cnt
);

    logic              m_valid, m_load, m_clear, drain;
    logic [DATA_W-1:0] m_din, m_data;
    logic [CTRL_W-1:0] m_cin, m_ctrl;
    logic [CNT_W-1:0]  stall_q, stall_d;

    assign drain   = m_valid & out_ready;
    assign m_clear = flush | drain;

    generate
        if (SKID == SKID_ON) begin : g_skid
            logic              s_valid, s_load, s_clear, accept;
            logic [DATA_W-1:0] s_data;
            logic [CTRL_W-1:0] s_ctrl;

            // Ready depends only on the skid flag, so no combinational path from out_ready.
            assign in_ready = !s_valid;
            assign accept   = in_valid & !s_valid;
            assign s_load   = !flush & accept & m_valid & !drain;
            assign s_clear  = flush | drain;
            assign m_load   = !flush & ((drain & s_valid) | (accept & (!m_valid | drain)));
            assign m_din    = s_valid ? s_data : in_data;
            assign m_cin    = s_valid ? s_ctrl : in_ctrl;

            pipe_slot #(
                .DATA_W (DATA_W),
                .CTRL_W (CTRL_W)
            ) u_skid_slot (
                .clk     (clk),
                .rst     (rst),
                .load_i  (s_load),
                .clear_i (s_clear),
                .data_i  (in_data),
                .ctrl_i  (in_ctrl),
                .valid_o (s_valid),
                .data_o  (s_data),
                .ctrl_o  (s_ctrl)
            );
        end else begin : g_single
            logic accept;

            assign in_ready = !m_valid | out_ready;
            assign accept   = in_valid & in_ready;
            assign m_load   = !flush & accept;
            assign m_din    = in_data;
            assign m_cin    = in_ctrl;
        end
    endgenerate

    pipe_slot #(
        .DATA_W (DATA_W),
        .CTRL_W (CTRL_W)
    ) u_main_slot (
        .clk     (clk),
        .rst     (rst),
        .load_i  (m_load),
        .clear_i (m_clear),
        .data_i  (m_din),
        .ctrl_i  (m_cin),
        .valid_o (m_valid),
        .data_o  (m_data),
        .ctrl_o  (m_ctrl)
    );

    always_comb begin
        stall_d = stall_q;
        if (m_valid && !out_ready) begin
            stall_d = CNT_W'(sat_inc(SAT_MAX_W'(stall_q), CNT_W));
        end
    end

    // NOTE: sequential state uses non-blocking assignments only.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stall_q <= '0;
        end else begin
            stall_q <= stall_d;
        end
    end

    assign out_valid = m_valid;
    assign out_data  = m_data;
    assign out_ctrl  = m_valid ? m_ctrl : '0;
    assign stall_cnt = stall_q;

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Bench for pipe_stage_reg: three configurations share stimulus, checked against a queue model.
module tb_pipe_stage_reg;
    import pipe_pkg::*;

    localparam int DW = 32;
    localparam int CW = 8;
    localparam int ND = 3;   // 0: SKID=1 CNT_W=16, 1: SKID=0 CNT_W=16, 2: SKID=1 CNT_W=4

    logic          clk = 1'b0;
    logic          rst, flush, in_valid, out_ready;
    logic [DW-1:0] in_data;
    logic [CW-1:0] in_ctrl;
    logic          rdy [ND];
    logic          ov  [ND];
    logic [DW-1:0] od  [ND];
    logic [CW-1:0] oc  [ND];
    logic [15:0]   sc0, sc1;
    logic [3:0]    sc2;
    logic [15:0]   sc  [ND];

    logic [DW+CW-1:0] mq [ND][$];
    int               mcnt [ND];
    int               n_cmp = 0;
    int               n_bad = 0;

    always #5 clk = ~clk;

    assign sc[0] = sc0;
    assign sc[1] = sc1;
    assign sc[2] = {12'd0, sc2};

    pipe_stage_reg #(.DATA_W(DW), .CTRL_W(CW), .SKID(1'b1), .CNT_W(16)) dut_skid (
        .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(rdy[0]),
        .in_data(in_data), .in_ctrl(in_ctrl), .out_valid(ov[0]), .out_ready(out_ready),
        .out_data(od[0]), .out_ctrl(oc[0]), .stall_cnt(sc0));

    pipe_stage_reg #(.DATA_W(DW), .CTRL_W(CW), .SKID(1'b0), .CNT_W(16)) dut_single (
        .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(rdy[1]),
        .in_data(in_data), .in_ctrl(in_ctrl), .out_valid(ov[1]), .out_ready(out_ready),
        .out_data(od[1]), .out_ctrl(oc[1]), .stall_cnt(sc1));

    pipe_stage_reg #(.DATA_W(DW), .CTRL_W(CW), .SKID(1'b1), .CNT_W(4)) dut_cnt4 (
        .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(rdy[2]),
        .in_data(in_data), .in_ctrl(in_ctrl), .out_valid(ov[2]), .out_ready(out_ready),
        .out_data(od[2]), .out_ctrl(oc[2]), .stall_cnt(sc2));

    // Reference model: each stage is a FIFO of capacity 2 (skid) or 1 (single slot).
    function automatic bit m_ready(int k);
        if (k == 1) return (mq[k].size() == 0) || out_ready;
        return mq[k].size() < 2;
    endfunction

    function automatic int cnt_max(int k);
        return (k == 2) ? 15 : 65535;
    endfunction

    function automatic logic [CW-1:0] e_ctrl(int k);
        return (mq[k].size() != 0) ? mq[k][0][CW-1:0] : '0;
    endfunction

    function automatic logic [DW-1:0] e_data(int k);
        return (mq[k].size() != 0) ? mq[k][0][DW+CW-1:CW] : '0;
    endfunction

    task automatic model_clear();
        for (int k = 0; k < ND; k++) begin
            mq[k].delete();
            mcnt[k] = 0;
        end
    endtask

    // Called just after a falling edge; outputs are sampled 1 time unit later.
    task automatic drive(bit v, logic [DW-1:0] d, logic [CW-1:0] c, bit r, bit f);
        in_valid  = v;
        in_data   = v ? d : 'x;
        in_ctrl   = v ? c : 'x;
        out_ready = r;
        flush     = f;
        #1;
    endtask

    task automatic tick();
        bit acc [ND];
        bit drn [ND];
        for (int k = 0; k < ND; k++) begin
            acc[k] = in_valid && m_ready(k);
            drn[k] = (mq[k].size() != 0) && out_ready;
            if (mq[k].size() != 0 && !out_ready && mcnt[k] < cnt_max(k)) mcnt[k]++;
            if (drn[k]) void'(mq[k].pop_front());
            if (flush) mq[k].delete();
            else if (acc[k]) mq[k].push_back({in_data, in_ctrl});
        end
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        drive(0, '0, '0, 0, 0);
        model_clear();
        @(negedge clk);
        rst = 1'b0;
        #1;
    endtask

    task automatic test_reset();
        do_reset();
        drive(1, 32'h5, 8'h3, 0, 0);
        tick();
        drive(0, '0, '0, 0, 0);
        tick();
        rst = 1'b1;
        #1;
        for (int k = 0; k < ND; k++) begin
            n_cmp++;
            if (ov[k] !== 1'b0 || oc[k] !== '0 || sc[k] !== 16'd0) begin
                n_bad++;
                $display("FAIL reset_async dut%0d: valid=%b ctrl=%h cnt=%0d, required 0/00/0",
                         k, ov[k], oc[k], sc[k]);
            end
        end
        model_clear();
        @(negedge clk);
        rst = 1'b0;
        #1;
        for (int k = 0; k < ND; k++) begin
            n_cmp++;
            if (rdy[k] !== 1'b1 || ov[k] !== 1'b0) begin
                n_bad++;
                $display("FAIL reset_release dut%0d: in_ready=%b valid=%b, required 1/0",
                         k, rdy[k], ov[k]);
            end
        end
    endtask

    task automatic test_first_beat();
        do_reset();
        drive(1, 32'h1000_0004, 8'h15, 1, 0);
        tick();
        drive(0, '0, '0, 1, 0);
        for (int k = 0; k < ND; k++) begin
            n_cmp++;
            if (ov[k] !== 1'b1 || od[k] !== 32'h1000_0004 || oc[k] !== 8'h15 || sc[k] !== 16'd0) begin
                n_bad++;
                $display("FAIL first_beat dut%0d: valid=%b data=%h ctrl=%h cnt=%0d, required 1/10000004/15/0",
                         k, ov[k], od[k], oc[k], sc[k]);
            end
        end
    endtask

    task automatic test_stream();
        do_reset();
        for (int i = 1; i <= 9; i++) begin
            drive(i <= 8, 32'(i), 8'(i), 1, 0);
            n_cmp++;
            if (rdy[0] !== 1'b1) begin
                n_bad++;
                $display("FAIL stream_ready step %0d: in_ready=%b, required 1", i, rdy[0]);
            end
            if (i > 1) begin
                n_cmp++;
                if (ov[0] !== 1'b1 || od[0] !== 32'(i - 1)) begin
                    n_bad++;
                    $display("FAIL stream_data step %0d: valid=%b data=%0d, required 1/%0d",
                             i, ov[0], od[0], i - 1);
                end
            end
            tick();
        end
    endtask

    task automatic test_fill_stall();
        do_reset();
        drive(1, 32'hAAAA_0001, 8'h81, 0, 0);
        tick();
        drive(1, 32'hBBBB_0002, 8'h42, 0, 0);
        n_cmp++;
        if (rdy[0] !== 1'b1) begin
            n_bad++;
            $display("FAIL fill_ready_b: in_ready=%b, required 1", rdy[0]);
        end
        tick();
        for (int i = 1; i <= 4; i++) begin
            if (i > 1) tick();
            drive(0, '0, '0, 0, 0);
            n_cmp++;
            if (rdy[0] !== 1'b0 || ov[0] !== 1'b1 || od[0] !== 32'hAAAA_0001 || sc[0] !== 16'(i)) begin
                n_bad++;
                $display("FAIL fill_hold %0d: in_ready=%b valid=%b data=%h cnt=%0d, required 0/1/aaaa0001/%0d",
                         i, rdy[0], ov[0], od[0], sc[0], i);
            end
        end
        drive(0, '0, '0, 1, 0);
        n_cmp++;
        if (od[0] !== 32'hAAAA_0001 || oc[0] !== 8'h81) begin
            n_bad++;
            $display("FAIL drain_a: data=%h ctrl=%h, required aaaa0001/81", od[0], oc[0]);
        end
        tick();
        drive(0, '0, '0, 1, 0);
        n_cmp++;
        if (ov[0] !== 1'b1 || od[0] !== 32'hBBBB_0002 || oc[0] !== 8'h42 || rdy[0] !== 1'b1) begin
            n_bad++;
            $display("FAIL drain_b: valid=%b data=%h ctrl=%h in_ready=%b, required 1/bbbb0002/42/1",
                     ov[0], od[0], oc[0], rdy[0]);
        end
        tick();
        n_cmp++;
        if (ov[0] !== 1'b0 || oc[0] !== '0 || sc[0] !== 16'd4) begin
            n_bad++;
            $display("FAIL drained_empty: valid=%b ctrl=%h cnt=%0d, required 0/00/4", ov[0], oc[0], sc[0]);
        end
    endtask

    task automatic test_flush();
        do_reset();
        drive(1, 32'hA, 8'h11, 0, 0);
        tick();
        drive(1, 32'hB, 8'h22, 0, 0);
        tick();
        drive(1, 32'hC, 8'h33, 1, 1);
        tick();
        for (int i = 0; i < 3; i++) begin
            drive(0, '0, '0, 1, 0);
            n_cmp++;
            if (ov[0] !== 1'b0 || oc[0] !== '0 || rdy[0] !== 1'b1) begin
                n_bad++;
                $display("FAIL flush_full %0d: valid=%b ctrl=%h in_ready=%b, required 0/00/1",
                         i, ov[0], oc[0], rdy[0]);
            end
            tick();
        end
        do_reset();
        drive(1, 32'hA, 8'h11, 0, 0);
        tick();
        drive(1, 32'hC, 8'h33, 0, 1);
        n_cmp++;
        if (rdy[0] !== 1'b1) begin
            n_bad++;
            $display("FAIL flush_accept_ready: in_ready=%b, required 1", rdy[0]);
        end
        tick();
        for (int i = 0; i < 2; i++) begin
            drive(0, '0, '0, 1, 0);
            n_cmp++;
            if (ov[0] !== 1'b0 || oc[0] !== '0) begin
                n_bad++;
                $display("FAIL flush_discard %0d: valid=%b ctrl=%h, required 0/00", i, ov[0], oc[0]);
            end
            tick();
        end
    endtask

    task automatic test_saturate();
        do_reset();
        drive(1, 32'h7, 8'h1, 0, 0);
        tick();
        drive(0, '0, '0, 0, 0);
        repeat (20) tick();
        n_cmp++;
        if (sc[2] !== 16'd15 || sc[0] !== 16'd20) begin
            n_bad++;
            $display("FAIL sat_reach: cnt4=%0d cnt16=%0d, required 15/20", sc[2], sc[0]);
        end
        repeat (2) tick();
        n_cmp++;
        if (sc[2] !== 16'd15) begin
            n_bad++;
            $display("FAIL sat_hold: cnt4=%0d, required 15", sc[2]);
        end
        drive(0, '0, '0, 0, 1);
        tick();
        drive(0, '0, '0, 0, 0);
        n_cmp++;
        if (ov[2] !== 1'b0 || sc[2] !== 16'd15 || sc[0] !== 16'd23) begin
            n_bad++;
            $display("FAIL sat_flush: valid=%b cnt4=%0d cnt16=%0d, required 0/15/23", ov[2], sc[2], sc[0]);
        end
        rst = 1'b1;
        #1;
        n_cmp++;
        if (sc[2] !== 16'd0) begin
            n_bad++;
            $display("FAIL sat_rst: cnt4=%0d, required 0", sc[2]);
        end
        model_clear();
        @(negedge clk);
        rst = 1'b0;
        #1;
    endtask

    task automatic test_random();
        do_reset();
        for (int i = 0; i < 600; i++) begin
            bit v, r, f;
            v = ($urandom_range(0, 3) != 0);
            r = (i < 150) ? i[0] : ($urandom_range(0, 2) != 0);
            f = ($urandom_range(0, 24) == 0);
            drive(v, $urandom, 8'($urandom), r, f);
            for (int k = 0; k < ND; k++) begin
                bit ev;
                ev = (mq[k].size() != 0);
                n_cmp++;
                if (rdy[k] !== m_ready(k) || ov[k] !== ev || oc[k] !== e_ctrl(k) ||
                    (ev && od[k] !== e_data(k)) || sc[k] !== 16'(mcnt[k])) begin
                    n_bad++;
                    $display("FAIL random dut%0d cyc %0d: rdy=%b valid=%b data=%h ctrl=%h cnt=%0d, required rdy=%b valid=%b data=%h ctrl=%h cnt=%0d",
                             k, i, rdy[k], ov[k], od[k], oc[k], sc[k],
                             m_ready(k), ev, e_data(k), e_ctrl(k), mcnt[k]);
                end
            end
            if (mq[1].size() != 0) begin
                n_cmp++;
                if (rdy[1] !== out_ready) begin
                    n_bad++;
                    $display("FAIL single_mirror cyc %0d: in_ready=%b, required %b", i, rdy[1], out_ready);
                end
            end
            tick();
        end
    endtask

    initial begin
        rst = 1'b1;
        model_clear();
        test_reset();
        test_first_beat();
        test_stream();
        test_fill_stall();
        test_flush();
        test_saturate();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
